// File: rtl/dds_loader.sv
// Write-side sequencer for one multi-channel dds: clears the parameter buffers, writes
// thetas/deltas/ampls from a stream, then starts circulation. Optional: DDS_LOADER_AUTOSTART_EN.
module dds_loader #(
  parameter int unsigned SIG_WIDTH = 16,
  parameter int unsigned N_CH      = 8,
  parameter int unsigned THETAS    = 0,
  parameter int unsigned DELTAS    = 1,
  parameter int unsigned AMPLS     = 2,
  parameter logic [8:0]  ADDR_IDLE = 9'h1FF
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic                        i_load_go,
  input  logic                        i_stop,
  input  logic                        i_start,
  input  logic                        s_valid,
  input  logic signed [SIG_WIDTH-1:0] s_data,
  output logic                        s_ready,
  output logic                        o_dds_rst,
  output logic                        o_dds_start,
  output logic [8:0]                  o_dds_addrs,
  output logic signed [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                        o_busy,
  output logic                        o_running,
  output logic                        o_done
);

  localparam int unsigned AW   = 9;
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_ARMED, S_RUN
  } state_e;

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [1:0]                    fld_q, fld_d;
  logic                          ready_q, ready_d;
  logic                          dds_rst_q, dds_rst_d;
  logic                          start_q, start_d;
  logic [AW-1:0]                 addrs_q, addrs_d;
  logic signed [SIG_WIDTH-1:0]   data_q, data_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          hs_c;
  logic                          last_c;
  logic                          ch_wrap_c;
  logic [AW-1:0]                 fld_addr_c;

`ifdef DDS_LOADER_AUTOSTART_EN
  logic unused_start_c;
  assign unused_start_c = i_start;
`endif

  assign hs_c      = (state_q == S_LOAD) && s_valid && ready_q;
  assign ch_wrap_c = (ch_q == CH_W'(N_CH - 1));
  assign last_c    = hs_c && ch_wrap_c && (fld_q == 2'd2);

  always_comb begin
    case (fld_q)
      2'd0:    fld_addr_c = AW'(THETAS);
      2'd1:    fld_addr_c = AW'(DELTAS);
      default: fld_addr_c = AW'(AMPLS);
    endcase
  end

  // Next state, counters and the registered output values for the next cycle
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    fld_d     = fld_q;
    dds_rst_d = 1'b0;
    start_d   = 1'b0;
    addrs_d   = ADDR_IDLE;
    data_d    = '0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_load_go) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        ch_d  = '0;
        fld_d = '0;
        if (i_stop) begin
          state_d   = S_IDLE;
          dds_rst_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_stop) begin
          state_d   = S_IDLE;
          dds_rst_d = 1'b1;
        end else if (hs_c) begin
          addrs_d = fld_addr_c;
          data_d  = s_data;
          if (ch_wrap_c) begin
            ch_d  = '0;
            fld_d = fld_q + 2'd1;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
          if (last_c) begin
            state_d = S_FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (i_stop) begin
          state_d   = S_IDLE;
          dds_rst_d = 1'b1;
        end else begin
`ifdef DDS_LOADER_AUTOSTART_EN
          state_d = S_RUN;
          start_d = 1'b1;
`else
          state_d = S_ARMED;
`endif
        end
      end
      S_ARMED: begin
        if (i_load_go) begin
          state_d = S_CLEAR;
        end else if (i_stop) begin
          state_d = S_IDLE;
`ifndef DDS_LOADER_AUTOSTART_EN
        end else if (i_start) begin
          state_d = S_RUN;
          start_d = 1'b1;
`endif
        end
      end
      S_RUN: begin
        // Reload has priority over stop
        if (i_load_go) begin
          state_d = S_CLEAR;
        end else if (i_stop) begin
          state_d = S_IDLE;
        end else begin
          start_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CLEAR) dds_rst_d = 1'b1;
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      fld_q     <= '0;
      ready_q   <= 1'b0;
      dds_rst_q <= 1'b0;
      start_q   <= 1'b0;
      addrs_q   <= ADDR_IDLE;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      fld_q     <= fld_d;
      ready_q   <= ready_d;
      dds_rst_q <= dds_rst_d;
      start_q   <= start_d;
      addrs_q   <= addrs_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready         = ready_q;
  assign o_dds_rst       = dds_rst_q;
  assign o_dds_start     = start_q;
  assign o_running       = start_q;
  assign o_dds_addrs     = addrs_q;
  assign o_dds_fifo_data = data_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_dds_loader.sv
// Directed bench for dds_loader (N_CH=4): table-driven full load plus hand-written
// backpressure, abort, reload, start/stop and mid-load reset sequences.
module tb_dds_loader;

  localparam int unsigned SW = 16;
`ifdef DDS_LOADER_AUTOSTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic                 clk;
  logic                 a_rst_n;
  logic                 i_load_go, i_stop, i_start, s_valid;
  logic signed [SW-1:0] s_data;
  logic                 s_ready, o_dds_rst, o_dds_start, o_busy, o_running, o_done;
  logic [8:0]           o_dds_addrs;
  logic signed [SW-1:0] o_dds_fifo_data;

  int n_cmp = 0;
  int n_err = 0;

  dds_loader #(.SIG_WIDTH(SW), .N_CH(4)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_load_go(i_load_go), .i_stop(i_stop),
    .i_start(i_start), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_dds_rst(o_dds_rst), .o_dds_start(o_dds_start), .o_dds_addrs(o_dds_addrs),
    .o_dds_fifo_data(o_dds_fifo_data), .o_busy(o_busy), .o_running(o_running),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        go, stop, start, valid;
    logic [15:0] data;
    logic        e_ready, e_rst, e_start;
    logic [8:0]  e_addr;
    logic [15:0] e_data;
    logic        e_busy, e_done;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic go, logic stop, logic valid, logic [15:0] data,
                              logic e_ready, logic e_rst, logic e_start, logic [8:0] e_addr,
                              logic [15:0] e_data, logic e_busy, logic e_done);
    vec_t v;
    v.go = go; v.stop = stop; v.start = 1'b0; v.valid = valid; v.data = data;
    v.e_ready = e_ready; v.e_rst = e_rst; v.e_start = e_start; v.e_addr = e_addr;
    v.e_data = e_data; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ready, input logic rst,
                         input logic start, input logic [8:0] addr, input logic [15:0] data,
                         input logic busy, input logic done);
    chk({tag, " s_ready"}, 32'(s_ready), 32'(ready));
    chk({tag, " dds_rst"}, 32'(o_dds_rst), 32'(rst));
    chk({tag, " dds_start"}, 32'(o_dds_start), 32'(start));
    chk({tag, " running"}, 32'(o_running), 32'(start));
    chk({tag, " addrs"}, 32'(o_dds_addrs), 32'(addr));
    chk({tag, " fifo_data"}, 32'(o_dds_fifo_data), 32'(data));
    chk({tag, " busy"}, 32'(o_busy), 32'(busy));
    chk({tag, " done"}, 32'(o_done), 32'(done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered with the first LOAD cycle visible; valid asserted once every gap+1 cycles
  task automatic run_load(input logic [15:0] base, input int gap, input string tag);
    int n = 0;
    int t = 0;
    while (n < 12 && t < 200) begin
      s_valid = (t % (gap + 1) == 0);
      s_data  = base + 16'(n);
      step();
      if (s_valid) begin
        chk_all(tag, (n != 11), 1'b0, 1'b0, 9'(n / 4), base + 16'(n), 1'b1, (n == 11));
        n++;
      end else begin
        chk_all(tag, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b1, 1'b0);
      end
      t++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    chk({tag, " write count"}, 32'(n), 32'd12);
  endtask

  // From the FLUSH cycle into RUN
  task automatic to_run(input string tag);
    step();
`ifndef DDS_LOADER_AUTOSTART_EN
    chk({tag, " armed start"}, 32'(o_dds_start), 32'd0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
`endif
    chk_all({tag, " run"}, 1'b0, 1'b0, 1'b1, 9'h1FF, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic begin_load(input string tag);
    i_load_go = 1'b1;
    step();
    i_load_go = 1'b0;
    chk_all({tag, " clear"}, 1'b0, 1'b1, 1'b0, 9'h1FF, 16'h0, 1'b1, 1'b0);
    step();
    chk_all({tag, " load"}, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic stop_run(input string tag);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk_all({tag, " stopped"}, 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    a_rst_n = 1'b0; i_load_go = 1'b0; i_stop = 1'b0; i_start = 1'b0;
    s_valid = 1'b0; s_data = '0;

    tbl[0] = mk(1, 0, 0, 16'h0, 0, 1, 0, 9'h1FF, 16'h0, 1, 0);
    tbl[1] = mk(0, 0, 0, 16'h0, 1, 0, 0, 9'h1FF, 16'h0, 1, 0);
    for (int j = 0; j < 12; j++)
      tbl[2+j] = mk(0, 0, 1, 16'h0100 + 16'(j), (j != 11), 0, 0, 9'(j / 4),
                    16'h0100 + 16'(j), 1, (j == 11));
    tbl[14] = mk(0, 0, 0, 16'h0, 0, 0, AUTO, 9'h1FF, 16'h0, 0, 0);

    #11;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
    #1 a_rst_n = 1'b1;
    step();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);

    // Full back-to-back load
    for (int i = 0; i < 15; i++) begin
      i_load_go = tbl[i].go; i_stop = tbl[i].stop; i_start = tbl[i].start;
      s_valid = tbl[i].valid; s_data = tbl[i].data;
      step();
      chk_all($sformatf("full[%0d]", i), tbl[i].e_ready, tbl[i].e_rst, tbl[i].e_start,
              tbl[i].e_addr, tbl[i].e_data, tbl[i].e_busy, tbl[i].e_done);
    end
    i_load_go = 1'b0; s_valid = 1'b0; s_data = '0;

`ifndef DDS_LOADER_AUTOSTART_EN
    for (int i = 0; i < 10; i++) begin
      step();
      chk("armed hold start", 32'(o_dds_start), 32'd0);
    end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
`else
    step();
`endif
    chk_all("full run", 1'b0, 1'b0, 1'b1, 9'h1FF, 16'h0, 1'b0, 1'b0);
    stop_run("full");

    // Backpressure: valid 1,0,0,1,...
    begin_load("bp");
    run_load(16'h0200, 2, "bp");
    to_run("bp");
    stop_run("bp");

    // Abort after five handshakes
    begin_load("abort");
    for (int j = 0; j < 5; j++) begin
      s_valid = 1'b1; s_data = 16'h0500 + 16'(j);
      step();
      chk("abort addr", 32'(o_dds_addrs), 32'(j / 4));
    end
    s_valid = 1'b0; i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk_all("abort stop", 1'b0, 1'b1, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk_all("abort idle", 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
    end

    // Reload from RUN with load_go and stop together
    begin_load("rl1");
    run_load(16'h0300, 0, "rl1");
    to_run("rl1");
    i_load_go = 1'b1; i_stop = 1'b1;
    step();
    i_load_go = 1'b0; i_stop = 1'b0;
    chk_all("reload clear", 1'b0, 1'b1, 1'b0, 9'h1FF, 16'h0, 1'b1, 1'b0);
    step();
    chk_all("reload load", 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b1, 1'b0);
    run_load(16'h0400, 1, "rl2");
    to_run("rl2");
    stop_run("rl2");

    // Asynchronous reset in the middle of LOAD
    begin_load("rst");
    for (int j = 0; j < 3; j++) begin
      s_valid = 1'b1; s_data = 16'h0600 + 16'(j);
      step();
    end
    chk("rst pre addr", 32'(o_dds_addrs), 32'd0);
    #2 a_rst_n = 1'b0;
    #1;
    chk_all("rst async", 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);
    #1 a_rst_n = 1'b1;
    s_valid = 1'b0; s_data = '0;
    step();
    chk_all("rst after", 1'b0, 1'b0, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
